wb_writer: RTL and testbench

- Write-side driver for the 32x32 register file port (rd, data, writeEnable).
- Merges two result producers into the single write port:
  - single-cycle ALU: never stalls, always has priority;
  - load unit: valid/ready handshake, buffered in a small FIFO.
- Drops writes to x0.
- Kills stale buffered load writes when a younger ALU result targets the same register (WAW).
- Exports a pending-register mask for the hazard logic.

---
 rtl/wb_writer.sv | 124 ++++++++++++
 tb/tb_wb_writer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// Register-file write-port driver: merges the ALU and a load FIFO, drops x0 writes, kills stale loads.
// Optional WB_KILL_STATS_EN adds a saturating count of popped killed loads.
module wb_writer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   input  logic [4:0]    alu_rd,
   input  logic [31:0]   alu_data,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [4:0]    ld_rd,
   input  logic [31:0]   ld_data,
   output logic [4:0]    rd,
   output logic [31:0]   data,
   output logic          writeEnable,
   output logic [31:0]   pending_mask,
   output logic [AW:0]   fifo_count
`ifdef WB_KILL_STATS_EN
   ,
   output logic [15:0]   kill_count
`endif
);

   logic [4:0]       ent_rd   [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [DEPTH-1:0] ent_live;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             alu_wr;
   logic             push;
   logic             pop;
   logic             push_live;

   assign alu_wr     = alu_valid && (alu_rd != 5'd0);
   assign ld_ready   = (count != (AW+1)'(DEPTH));
   assign push       = ld_valid && ld_ready;
   assign pop        = !alu_valid && (count != '0);
   // A load arriving with a same-register ALU result is the older write, so it is born dead.
   assign push_live  = (ld_rd != 5'd0) && !(alu_valid && (alu_rd == ld_rd));
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd[wr_ptr]   <= ld_rd;
         ent_data[wr_ptr] <= ld_data;
      end
   end

   // Live bits double as occupancy for the mask, so a popped slot is cleared as it leaves.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_live <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr && (ent_rd[i] == alu_rd))
               ent_live[i] <= 1'b0;
         end
         if (pop)
            ent_live[rd_ptr] <= 1'b0;
         if (push)
            ent_live[wr_ptr] <= push_live;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // ALU always wins the port; the FIFO head drains only on cycles with no ALU result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd          <= 5'd0;
         data        <= 32'd0;
         writeEnable <= 1'b0;
      end else if (alu_wr) begin
         rd          <= alu_rd;
         data        <= alu_data;
         writeEnable <= 1'b1;
      end else if (pop) begin
         rd          <= ent_rd[rd_ptr];
         data        <= ent_data[rd_ptr];
         writeEnable <= ent_live[rd_ptr];
      end else begin
         writeEnable <= 1'b0;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_live[i])
            pending_mask[ent_rd[i]] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

`ifdef WB_KILL_STATS_EN
   // Only loads killed by a younger ALU write count; x0 loads were never real writes.
   always_ff @(posedge clk) begin
      if (!reset)
         kill_count <= 16'd0;
      else if (pop && !ent_live[rd_ptr] && (ent_rd[rd_ptr] != 5'd0) && (kill_count != 16'hFFFF))
         kill_count <= kill_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: queue-based reference model compared every cycle, plus directed literal checks.
// Also checks kill_count when WB_KILL_STATS_EN is defined.
module tb_wb_writer;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic [4:0]  rd;
   logic [31:0] data;
   logic        writeEnable;
   logic [31:0] pending_mask;
   logic [AW:0] fifo_count;
`ifdef WB_KILL_STATS_EN
   logic [15:0] kill_count;
`endif

   wb_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_rd        (ld_rd),
      .ld_data      (ld_data),
      .rd           (rd),
      .data         (data),
      .writeEnable  (writeEnable),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
`ifdef WB_KILL_STATS_EN
      ,
      .kill_count   (kill_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t        q[$];
   ent_t        m_head;
   ent_t        m_new;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        m_we;
   int          m_kills;
   bit          m_valid = 0;
   bit          m_can_push;
   logic [31:0] m_mask;

   // Reference model: a plain queue of pending loads, updated with the inputs seen at each edge.
   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         m_rd    = 5'd0;
         m_data  = 32'd0;
         m_we    = 1'b0;
         m_kills = 0;
         m_valid = 1;
      end else begin
         m_can_push = (q.size() < DEPTH);
         if (alu_valid && alu_rd != 5'd0) begin
            m_rd   = alu_rd;
            m_data = alu_data;
            m_we   = 1'b1;
            foreach (q[i])
               if (q[i].rd == alu_rd) q[i].live = 0;
         end else if (alu_valid) begin
            m_we = 1'b0;
         end else if (q.size() > 0) begin
            m_head = q.pop_front();
            m_rd   = m_head.rd;
            m_data = m_head.data;
            m_we   = m_head.live;
            if (!m_head.live && m_head.rd != 5'd0 && m_kills < 16'hFFFF)
               m_kills++;
         end else begin
            m_we = 1'b0;
         end
         if (ld_valid && m_can_push) begin
            m_new.rd   = ld_rd;
            m_new.data = ld_data;
            m_new.live = (ld_rd != 5'd0) && !(alu_valid && alu_rd == ld_rd);
            q.push_back(m_new);
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         m_mask = 32'd0;
         foreach (q[i])
            if (q[i].live) m_mask[q[i].rd] = 1'b1;
         checkOutput("model_rd", 32'(rd), 32'(m_rd));
         checkOutput("model_data", data, m_data);
         checkOutput("model_we", 32'(writeEnable), 32'(m_we));
         checkOutput("model_count", 32'(fifo_count), 32'(q.size()));
         checkOutput("model_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
         checkOutput("model_mask", pending_mask, m_mask);
`ifdef WB_KILL_STATS_EN
         checkOutput("model_kills", 32'(kill_count), 32'(m_kills));
`endif
      end
   end

   task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = ad;
      ld_valid  = lv;
      ld_rd     = lr;
      ld_data   = ldd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;

      // Reset held with both producers active
      applyStimulus(1'b1, 5'd4, 32'hDEAD_0000, 1'b1, 5'd8, 32'hDEAD_0001);
      applyStimulus(1'b1, 5'd4, 32'hDEAD_0000, 1'b1, 5'd8, 32'hDEAD_0001);
      checkOutput("rst_we", 32'(writeEnable), 32'd0);
      checkOutput("rst_rd", 32'(rd), 32'd0);
      checkOutput("rst_data", data, 32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_ready", 32'(ld_ready), 32'd1);
      reset = 1'b1;

      // ALU only
      applyStimulus(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0);
      checkOutput("alu_rd", 32'(rd), 32'd5);
      checkOutput("alu_data", data, 32'hA5A5_0001);
      checkOutput("alu_we", 32'(writeEnable), 32'd1);
      idle();
      checkOutput("alu_idle_we", 32'(writeEnable), 32'd0);

      // Load through an empty FIFO
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
      checkOutput("ld_count1", 32'(fifo_count), 32'd1);
      checkOutput("ld_mask", pending_mask, 32'h0000_0080);
      idle();
      checkOutput("ld_rd", 32'(rd), 32'd7);
      checkOutput("ld_data", data, 32'h1234);
      checkOutput("ld_we", 32'(writeEnable), 32'd1);
      checkOutput("ld_count0", 32'(fifo_count), 32'd0);

      // Fill under ALU pressure, then drain in order
      for (int i = 1; i <= 4; i++)
         applyStimulus(1'b1, 5'd9, 32'h90 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i));
      checkOutput("fill_count", 32'(fifo_count), 32'd4);
      checkOutput("fill_ready", 32'(ld_ready), 32'd0);
      checkOutput("fill_mask", pending_mask, 32'h0000_001E);
      applyStimulus(1'b1, 5'd9, 32'h95, 1'b1, 5'd5, 32'h105);
      checkOutput("full_hold_count", 32'(fifo_count), 32'd4);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
      checkOutput("drain1_rd", 32'(rd), 32'd1);
      checkOutput("drain1_count", 32'(fifo_count), 32'd3);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
      checkOutput("drain2_rd", 32'(rd), 32'd2);
      checkOutput("drain2_count", 32'(fifo_count), 32'd3);
      idle();
      checkOutput("drain3_rd", 32'(rd), 32'd3);
      idle();
      checkOutput("drain4_rd", 32'(rd), 32'd4);
      checkOutput("drain4_data", data, 32'h104);
      idle();
      checkOutput("drain5_rd", 32'(rd), 32'd5);
      checkOutput("drain_count0", 32'(fifo_count), 32'd0);

      // WAW kill
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hCAFE);
      checkOutput("waw_mask_set", pending_mask, 32'h0000_0040);
      applyStimulus(1'b1, 5'd6, 32'hBEEF, 1'b0, 5'd0, 32'd0);
      checkOutput("waw_alu_data", data, 32'hBEEF);
      checkOutput("waw_mask_clr", pending_mask, 32'd0);
      idle();
      checkOutput("waw_pop_we", 32'(writeEnable), 32'd0);
      checkOutput("waw_pop_count", 32'(fifo_count), 32'd0);
`ifdef WB_KILL_STATS_EN
      checkOutput("waw_kills", 32'(kill_count), 32'd1);
`endif

      // Simultaneous same-register load, then an x0 load
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 32'h4444);
      checkOutput("sim_alu_rd", 32'(rd), 32'd3);
      checkOutput("sim_count", 32'(fifo_count), 32'd1);
      checkOutput("sim_mask", pending_mask, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
      checkOutput("sim_pop_we", 32'(writeEnable), 32'd0);
      checkOutput("x0_mask", pending_mask, 32'd0);
      idle();
      checkOutput("x0_pop_we", 32'(writeEnable), 32'd0);
      checkOutput("x0_count", 32'(fifo_count), 32'd0);
`ifdef WB_KILL_STATS_EN
      checkOutput("x0_kills", 32'(kill_count), 32'd2);
`endif

      // ALU to x0 blocks the pop and writes nothing
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA);
      applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0);
      checkOutput("alu_x0_we", 32'(writeEnable), 32'd0);
      checkOutput("alu_x0_count", 32'(fifo_count), 32'd1);
      idle();
      checkOutput("late_rd", 32'(rd), 32'd10);
      checkOutput("late_we", 32'(writeEnable), 32'd1);
      idle();
      idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
